// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Optional feature macro: CLKDIV_SYNC_EN (adds i_sync realignment).
package clkdiv_pkg;

  localparam int unsigned CLKDIV_NBITS   = 8;
  localparam int unsigned CLKDIV_NCH     = 2;
  localparam int unsigned CLKDIV_DIV_RST = 0;

  // Counter width for a given divisor width; never narrower than 1.
  function automatic int unsigned cnt_width(
    input int unsigned nbits
  );
    return (nbits < 1) ? 1 : nbits;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, shadow/active divisor,
// registered o_clk / o_tick / o_pend.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned NBITS   = CLKDIV_NBITS,
  parameter int unsigned DIV_RST = CLKDIV_DIV_RST
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic [NBITS-1:0] i_div,
  input  logic             i_load,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pend
);

  localparam int unsigned CW = cnt_width(NBITS);
  localparam logic [CW-1:0] DIV_RST_V = CW'(DIV_RST);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] act_q, act_d;
  logic [CW-1:0] shd_q, shd_d;
  logic          clk_q, clk_d;
  logic          tick_q, tick_d;
  logic          pend_q, pend_d;
  logic          tc;
  logic          apply;

  // Next-state: terminal count toggles and swaps in the shadow divisor.
  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    act_d  = act_q;
    apply  = 1'b0;
    tc     = (cnt_q == act_q);
    shd_d  = i_load ? i_div : shd_q;
    if (i_sync) begin
      cnt_d = '0;
      clk_d = 1'b0;
      act_d = shd_q;
      apply = 1'b1;
    end else if (i_en) begin
      if (tc) begin
        cnt_d  = '0;
        clk_d  = ~clk_q;
        tick_d = ~clk_q;
        act_d  = shd_q;
        apply  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // A load in the apply cycle stays pending for the next half-period.
    pend_d = i_load | (pend_q & ~apply);
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      act_q  <= DIV_RST_V;
      shd_q  <= DIV_RST_V;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
    end
  end

  assign o_clk  = clk_q;
  assign o_tick = tick_q;
  assign o_pend = pend_q;

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel runtime-programmable clock divider / tick generator.
// Define CLKDIV_SYNC_EN to add the i_sync channel realignment input.
module prog_clk_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned NBITS   = CLKDIV_NBITS,
  parameter int unsigned NCH     = CLKDIV_NCH,
  parameter int unsigned DIV_RST = CLKDIV_DIV_RST
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NCH-1:0]       i_en,
  input  logic [NCH*NBITS-1:0] i_div,
  input  logic [NCH-1:0]       i_load,
`ifdef CLKDIV_SYNC_EN
  input  logic                 i_sync,
`endif
  output logic [NCH-1:0]       o_clk,
  output logic [NCH-1:0]       o_tick,
  output logic [NCH-1:0]       o_pend
);

  logic sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = i_sync;
`else
  assign sync = 1'b0;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    clkdiv_channel #(
      .NBITS   (NBITS),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (i_en[k]),
      .i_sync (sync),
      .i_div  (i_div[k*NBITS +: NBITS]),
      .i_load (i_load[k]),
      .o_clk  (o_clk[k]),
      .o_tick (o_tick[k]),
      .o_pend (o_pend[k])
    );
  end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed self-checking bench for prog_clk_divider.
// Honors CLKDIV_SYNC_EN to exercise the i_sync realignment.
module tb_prog_clk_divider;

  localparam int NB = 8;
  localparam int NC = 2;
  localparam int DR = 3;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic [NC-1:0]    i_en = '0;
  logic [NC*NB-1:0] i_div = '0;
  logic [NC-1:0]    i_load = '0;
`ifdef CLKDIV_SYNC_EN
  logic             i_sync = 1'b0;
`endif
  logic [NC-1:0]    o_clk;
  logic [NC-1:0]    o_tick;
  logic [NC-1:0]    o_pend;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  prog_clk_divider #(
    .NBITS   (NB),
    .NCH     (NC),
    .DIV_RST (DR)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_div  (i_div),
    .i_load (i_load),
`ifdef CLKDIV_SYNC_EN
    .i_sync (i_sync),
`endif
    .o_clk  (o_clk),
    .o_tick (o_tick),
    .o_pend (o_pend)
  );

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    i_rst  = 1'b1;
    i_en   = '0;
    i_load = '0;
    i_div  = '0;
`ifdef CLKDIV_SYNC_EN
    i_sync = 1'b0;
`endif
    step(2);
    i_rst = 1'b0;
  endtask

  // Edges until o_tick[k] is seen; -1 if the budget runs out.
  task automatic wait_tick(
    input  int k,
    input  int max,
    output int n
  );
    int c;
    c = 0;
    n = -1;
    while (c < max) begin
      step(1);
      c++;
      if (o_tick[k]) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int t0;
    int t1;

    // Reset state and default divisor, then div 0 on ch1
    do_reset();
    chk("rst_clk", int'(o_clk), 0);
    chk("rst_tick", int'(o_tick), 0);
    chk("rst_pend", int'(o_pend), 0);
    i_en = 2'b11;
    wait_tick(0, 20, n);
    chk("a_first_tick", n, 4);
    chk("a_both_tick", int'(o_tick), 3);
    wait_tick(0, 20, n);
    chk("a_period8", n, 8);
    i_div  = {8'd0, 8'd3};
    i_load = 2'b10;
    step(1);
    i_load = '0;
    chk("a_pend1", int'(o_pend), 2);
    wait_tick(1, 20, n);
    chk("a_ch1_apply", n, 4);
    chk("a_pend_clr", int'(o_pend), 0);
    wait_tick(1, 20, n);
    chk("a_ch1_period2", n, 2);

    // Load mid half-period: current half keeps old divisor
    do_reset();
    i_en = 2'b01;
    wait_tick(0, 20, n);
    chk("b_first_tick", n, 4);
    step(2);
    i_div  = {8'd0, 8'd5};
    i_load = 2'b01;
    step(1);
    i_load = '0;
    chk("b_pend", int'(o_pend[0]), 1);
    chk("b_clk_hi", int'(o_clk[0]), 1);
    step(1);
    chk("b_fall", int'(o_clk[0]), 0);
    chk("b_pend_clr", int'(o_pend[0]), 0);
    wait_tick(0, 30, n);
    chk("b_low6", n, 6);
    wait_tick(0, 30, n);
    chk("b_period12", n, 12);

    // Load coincident with terminal count
    do_reset();
    i_en = 2'b01;
    wait_tick(0, 20, n);
    step(3);
    i_div  = {8'd0, 8'd1};
    i_load = 2'b01;
    step(1);
    i_load = '0;
    chk("c_fall", int'(o_clk[0]), 0);
    chk("c_pend", int'(o_pend[0]), 1);
    wait_tick(0, 20, n);
    chk("c_old_half", n, 4);
    chk("c_pend_clr", int'(o_pend[0]), 0);
    wait_tick(0, 20, n);
    chk("c_period4", n, 4);

    // Freeze ch0 for 10 cycles mid-count
    do_reset();
    i_en = 2'b11;
    wait_tick(0, 20, n);
    step(1);
    i_en = 2'b10;
    t0 = 0;
    t1 = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      t0 += int'(o_tick[0]);
      t1 += int'(o_tick[1]);
    end
    chk("d_no_tick0", t0, 0);
    chk("d_clk0_hold", int'(o_clk[0]), 1);
    chk("d_ch1_runs", t1, 1);
    i_en = 2'b11;
    wait_tick(0, 20, n);
    chk("d_resume", n, 7);

    // Reset mid-period with a pending load
    do_reset();
    i_en = 2'b01;
    wait_tick(0, 20, n);
    step(1);
    i_div  = {8'd0, 8'd7};
    i_load = 2'b01;
    step(1);
    i_load = '0;
    chk("e_pend", int'(o_pend[0]), 1);
    i_rst = 1'b1;
    step(1);
    chk("e_clk", int'(o_clk), 0);
    chk("e_tick", int'(o_tick), 0);
    chk("e_pend_drop", int'(o_pend), 0);
    i_rst = 1'b0;
    wait_tick(0, 20, n);
    chk("e_first", n, 4);
    wait_tick(0, 20, n);
    chk("e_period", n, 8);

    // Max divisor loaded while disabled
    do_reset();
    i_div  = {8'd255, 8'd0};
    i_load = 2'b10;
    step(1);
    i_load = '0;
    chk("f_pend", int'(o_pend), 2);
    i_en = 2'b10;
    wait_tick(1, 20, n);
    chk("f_first", n, 4);
    chk("f_pend_clr", int'(o_pend), 0);
    wait_tick(1, 600, n);
    chk("f_period512", n, 512);
    chk("f_ch0_idle", int'(o_clk[0]), 0);

`ifdef CLKDIV_SYNC_EN
    // Realign channels at differing phases
    do_reset();
    i_en = 2'b01;
    step(2);
    i_en = 2'b11;
    step(1);
    i_sync = 1'b1;
    step(1);
    i_sync = 1'b0;
    chk("s_clk", int'(o_clk), 0);
    chk("s_tick", int'(o_tick), 0);
    wait_tick(0, 20, n);
    chk("s_first", n, 4);
    chk("s_aligned", int'(o_tick), 3);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
